fifo_rd_stream_adapter: RTL



---
 rtl/Asynchronous_FIFO_pkg.sv | 16 +
 rtl/rd_skid_buffer.sv | 63 ++++++
 rtl/fifo_rd_stream_adapter.sv | 76 +++++++
 3 files changed

// File: rtl/Asynchronous_FIFO_pkg.sv
// rtl/Asynchronous_FIFO_pkg.sv - shared constants and helpers for the async FIFO and its read-side adapter
package Asynchronous_FIFO_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;
    localparam int CNT_WIDTH  = 16;
    localparam int SKID_DEPTH = 3;

    typedef logic [1:0] skid_idx_t;

    // Circular index over SKID_DEPTH entries; 3 is not a power of two, so wrap explicitly.
    function automatic skid_idx_t skid_idx_next(input skid_idx_t idx);
        return (idx == skid_idx_t'(SKID_DEPTH - 1)) ? skid_idx_t'(0) : idx + skid_idx_t'(1);
    endfunction

endpackage

// File: rtl/rd_skid_buffer.sv
// rtl/rd_skid_buffer.sv - 3-entry circular skid buffer absorbing the FIFO read latency
module rd_skid_buffer
    import Asynchronous_FIFO_pkg::*;
#(
    parameter int WIDTH = Asynchronous_FIFO_pkg::DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    skid_idx_t        wr_idx_q, wr_idx_d;
    skid_idx_t        rd_idx_q, rd_idx_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;

    // Push never overflows: the requester only reads while count + inflight < SKID_DEPTH.
    assign do_pop = pop_i && (count_q != 2'd0);

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (push_i) begin
            wr_idx_d = skid_idx_next(wr_idx_q);
        end
        if (do_pop) begin
            rd_idx_d = skid_idx_next(rd_idx_q);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_idx_q] <= push_data_i;
            end
        end
    end

    assign head_data_o = mem_q[rd_idx_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO read port to valid/ready stream with bursts and word count
module fifo_rd_stream_adapter
    import Asynchronous_FIFO_pkg::*;
#(
    parameter int DATA_WIDTH = Asynchronous_FIFO_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = Asynchronous_FIFO_pkg::BURST_LEN,
    parameter int CNT_WIDTH  = Asynchronous_FIFO_pkg::CNT_WIDTH
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    logic                  inflight_q, inflight_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] head_data;
    logic [2:0]            occupancy;
    logic                  pop;

    rd_skid_buffer #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_rd),
        .rst_ni      (rst_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_out),
        .pop_i       (pop),
        .head_data_o (head_data),
        .count_o     (skid_count)
    );

    // Reserve a slot for the word already in flight so a read is never issued without room.
    assign occupancy  = {1'b0, skid_count} + {2'b00, inflight_q};
    assign fifo_rd_en = rst_n && !fifo_empty && (occupancy < 3'(SKID_DEPTH));

    assign m_valid = (skid_count != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? head_data : '0;
    assign m_last  = m_valid && (beat_q == BEAT_MAX);
    assign word_count = word_count_q;

    always_comb begin
        inflight_d   = fifo_rd_en && !fifo_empty;
        beat_d       = beat_q;
        word_count_d = word_count_q;
        if (pop) begin
            beat_d       = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
            word_count_d = word_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q   <= 1'b0;
            beat_q       <= '0;
            word_count_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            beat_q       <= beat_d;
            word_count_q <= word_count_d;
        end
    end

endmodule
